riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
- Parametrised load/store unit with integrated data memory for the pipelined RISC-V core. Sits in the MEM stage.
- Accepts one load or store per handshake and supports byte, half, word and (when DATA_W=64) double accesses.
- Applies sign or zero extension on loads and byte-lane merging on stores.
- Models a configurable wait-state memory and drives the pipeline stall plus the debug bus (wr, rd, addr, wr_data, rd_data).

Parameters:
- DATA_W, 32, memory word width in bits; legal values 32 or 64.
- ADDR_W, 9, byte-address width; memory depth = 2^ADDR_W / (DATA_W/8) words.
- MEM_LATENCY, 1, wait cycles per access; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  access request present.
- req_ready  output  1  unit can accept a request; 1 only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data, right-aligned.
- LoadSize  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
- LoadSigned  input  1  1 = sign-extend the load, 0 = zero-extend.
- resp_valid  output  1  one-cycle pulse when the access completes.
- resp_rdata  output  DATA_W  extended load result; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal-size access; valid with resp_valid.
- stall  output  1  high from acceptance until resp_valid (inclusive).
- wr  output  1  memory-write strobe (debug).
- rd  output  1  memory-read-complete strobe (debug).
- addr  output  ADDR_W  byte address of the current access (debug).
- wr_data  output  DATA_W  merged word written to memory (debug).
- rd_data  output  DATA_W  extended load result (debug).

Behaviour:
- Reset values: all outputs 0 except req_ready = 1. FSM returns to IDLE. Wait counter cleared. Memory contents are not reset.
- Reset asserted mid-access aborts the access: no memory write, no resp_valid.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Request is accepted on req_valid && req_ready. Address, size, signedness, write flag and wdata are latched.
  - Latched request is legal: go to ACCESS, counter = MEM_LATENCY-1.
  - Latched request is illegal: go to DONE with err set.
  - stall rises in the cycle after acceptance.
- ACCESS:
  - Counter decrements each cycle.
  - On the cycle the counter equals 0:
    - Store: memory word updated with byte-enable merge; wr = 1 for that cycle.
    - Load: word read and extended; rd = 1 for that cycle.
    - Then go to DONE.
- DONE: resp_valid = 1 for exactly one cycle, then go to IDLE with req_ready = 1.
- Latency: resp_valid asserts MEM_LATENCY+1 cycles after the acceptance edge.
- Back-to-back requests: minimum spacing is MEM_LATENCY+2 cycles.
- req_valid while not ready is ignored; requests are not queued. Inputs may change freely after acceptance.
- Legal accesses:
  - Aligned when addr mod size == 0.
  - Size 11 is illegal when DATA_W=32.
  - Out-of-range is impossible by construction (ADDR_W covers the full array).
- Byte lanes: little-endian.
  - Lane index = addr[log2(DATA_W/8)-1:0].
  - Store replicates req_wdata into the selected lanes; other lanes keep their old value.
- Load extension: selected field shifted to bit 0, then filled with its MSB (LoadSigned = 1) or zeros.
- wr_data and rd_data hold their last value between strobes. addr updates on acceptance.
- Simultaneous reset and req_valid: reset wins.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses set resp_err and skip memory entirely (no wr or rd strobe). resp_rdata = 0.
- Undefined:
  - Misaligned addresses are aligned down to the access size (low bits forced to 0) and performed normally.
  - resp_err asserts only for an illegal size (11 with DATA_W=32).

Test Plan:
- DATA_W=32, MEM_LATENCY=1: store word 0xDEADBEEF at 0x010, then load word from 0x010 signed → resp_rdata = 0xDEADBEEF; resp_valid 2 cycles after each acceptance; stall high 2 cycles.
- Store byte 0x80 at 0x013 over the prior word; load byte 0x013 signed → 0xFFFFFF80; unsigned → 0x00000080; load word 0x010 → 0x80ADBEEF.
- Load half from 0x011 with macro defined → resp_err = 1, resp_rdata = 0, rd never pulses. Without macro → half at 0x010, 0x0000BEEF unsigned, resp_err = 0.
- MEM_LATENCY=4: hold req_valid high continuously → req_ready pulses once every 6 cycles; extra requests are not accepted while busy.
- DATA_W=64: store double 0x0123456789ABCDEF at 0x008; load word 0x00C signed → 0x0000000001234567; size 11 with DATA_W=32 → resp_err = 1.
- Assert reset during ACCESS of a store to 0x020 → no wr pulse; later load of 0x020 returns the pre-store value; req_ready = 1 immediately after reset.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: MEM-stage load/store unit with an integrated wait-state data memory.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them down.
module riscv_lsu #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        LoadSize,
  input  logic              LoadSigned,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  localparam int unsigned LaneW = $clog2(DATA_W / 8);
  localparam int unsigned Depth = 2 ** (ADDR_W - LaneW);
  localparam int unsigned CntW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  state_e state_q, state_d;

  logic [CntW-1:0]   cnt_q;
  logic [1:0]        size_q;
  logic              signed_q, write_q, err_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, wr_data_q, rd_data_q;
  logic [DATA_W-1:0] mem [Depth];

  logic                     accept, req_size_bad, req_illegal, access_fire;
  logic [ADDR_W-LaneW-1:0]  word_idx;
  logic [LaneW-1:0]         lane;
  logic [LaneW+2:0]         shamt;
  logic [DATA_W-1:0]        size_mask, lane_mask, old_word, merged, field, load_ext;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [LaneW-1:0] size_lsbs(input logic [1:0] size);
    return LaneW'((1 << size) - 1);
  endfunction

  assign accept       = req_valid && req_ready;
  assign req_size_bad = (DATA_W == 32) && (LoadSize == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
  assign req_illegal  = req_size_bad || ((req_addr[LaneW-1:0] & size_lsbs(LoadSize)) != '0);
`else
  assign req_illegal  = req_size_bad;
`endif

  // Lane offset is aligned down; with trapping enabled misaligned requests never get here.
  always_comb begin
    word_idx = addr[ADDR_W-1:LaneW];
    lane     = addr[LaneW-1:0] & ~size_lsbs(size_q);
    shamt    = {lane, 3'b000};
    case (size_q)
      2'b00:   size_mask = DATA_W'(8'hFF);
      2'b01:   size_mask = DATA_W'(16'hFFFF);
      2'b10:   size_mask = DATA_W'(32'hFFFF_FFFF);
      default: size_mask = '1;
    endcase
    old_word  = mem[word_idx];
    lane_mask = size_mask << shamt;
    merged    = (old_word & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    field     = (old_word >> shamt) & size_mask;
    load_ext  = field;
    // mask ^ (mask >> 1) isolates the field MSB.
    if (signed_q && (|(field & (size_mask ^ (size_mask >> 1))))) begin
      load_ext = field | ~size_mask;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = req_illegal ? StDone : StAccess;
      StAccess: if (cnt_q == '0) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == StIdle);
    stall       = (state_q != StIdle);
    resp_valid  = (state_q == StDone);
    resp_err    = resp_valid && err_q;
    resp_rdata  = rdata_q;
    access_fire = (state_q == StAccess) && (cnt_q == '0);
    wr          = access_fire && write_q;
    rd          = access_fire && !write_q;
    wr_data     = wr ? merged : wr_data_q;
    rd_data     = rd ? load_ext : rd_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      addr      <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
    end else begin
      if (accept) begin
        cnt_q    <= CntInit;
        addr     <= req_addr;
        size_q   <= LoadSize;
        signed_q <= LoadSigned;
        write_q  <= req_write;
        err_q    <= req_illegal;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
      end else if ((state_q == StAccess) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (wr) begin
        wr_data_q <= merged;
      end
      if (rd) begin
        rd_data_q <= load_ext;
        rdata_q   <= load_ext;
      end
    end
  end

  // Data memory is not reset; wr drops asynchronously with reset so aborted stores never land.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[word_idx] <= merged;
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: a 32-bit/latency-1 instance and a 64-bit/latency-4 instance.
module tb_riscv_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_write, a_signed, a_resp_valid, a_resp_err, a_stall, a_wr, a_rd;
  logic [8:0]  a_addr, a_dbg_addr;
  logic [1:0]  a_size;
  logic [31:0] a_wdata, a_resp_rdata, a_wr_data, a_rd_data;

  logic        b_valid, b_ready, b_write, b_signed, b_resp_valid, b_resp_err, b_stall, b_wr, b_rd;
  logic [8:0]  b_addr, b_dbg_addr;
  logic [1:0]  b_size;
  logic [63:0] b_wdata, b_resp_rdata, b_wr_data, b_rd_data;

  riscv_lsu #(.DATA_W(32), .ADDR_W(9), .MEM_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(rst), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .LoadSize(a_size), .LoadSigned(a_signed),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .stall(a_stall), .wr(a_wr), .rd(a_rd), .addr(a_dbg_addr), .wr_data(a_wr_data),
    .rd_data(a_rd_data)
  );

  riscv_lsu #(.DATA_W(64), .ADDR_W(9), .MEM_LATENCY(4)) u_dut_b (
    .clk(clk), .reset(rst), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .LoadSize(b_size), .LoadSigned(b_signed),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .stall(b_stall), .wr(b_wr), .rd(b_rd), .addr(b_dbg_addr), .wr_data(b_wr_data),
    .rd_data(b_rd_data)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [64:0] q_a[$];
  logic [64:0] q_b[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Response monitor: pops the expected {err, rdata} whenever a response is presented.
  always @(negedge clk) begin
    logic [64:0] e;
    if (a_resp_valid) begin
      chk("a_resp_expected", 64'(q_a.size() != 0), 64'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_resp_err", 64'(a_resp_err), 64'(e[64]));
        chk("a_resp_rdata", 64'(a_resp_rdata), {32'd0, e[31:0]});
      end
    end
    if (b_resp_valid) begin
      chk("b_resp_expected", 64'(q_b.size() != 0), 64'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_resp_err", 64'(b_resp_err), 64'(e[64]));
        chk("b_resp_rdata", b_resp_rdata, e[63:0]);
      end
    end
  end

  // Issue one request on instance sel (0 = A, 1 = B) and check its timing and strobes.
  task automatic issue(input int sel, input logic w, input logic [8:0] ad, input logic [63:0] wd,
                       input logic [1:0] sz, input logic sg, input logic ee,
                       input logic [63:0] er);
    int t, lat, nst, nrd, nwr, latency;
    logic rdy;
    latency = (sel == 0) ? 1 : 4;
    t = 0;
    while (!(sel == 0 ? a_ready : b_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 64'(sel == 0 ? a_ready : b_ready), 64'd1);
    if (sel == 0) begin
      a_valid = 1'b1; a_write = w; a_addr = ad; a_wdata = wd[31:0]; a_size = sz; a_signed = sg;
      q_a.push_back({ee, er});
    end else begin
      b_valid = 1'b1; b_write = w; b_addr = ad; b_wdata = wd; b_size = sz; b_signed = sg;
      q_b.push_back({ee, er});
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    lat = 0; nst = 0; nrd = 0; nwr = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (sel == 0) begin
        if (a_resp_valid && lat == 0) lat = k;
        nst += int'(a_stall); nrd += int'(a_rd); nwr += int'(a_wr); rdy = a_ready;
      end else begin
        if (b_resp_valid && lat == 0) lat = k;
        nst += int'(b_stall); nrd += int'(b_rd); nwr += int'(b_wr); rdy = b_ready;
      end
      if (rdy) break;
    end
    chk("latency", 64'(lat), ee ? 64'd1 : 64'(latency + 1));
    chk("stall_cycles", 64'(nst), ee ? 64'd1 : 64'(latency + 1));
    chk("rd_pulses", 64'(nrd), 64'(!ee && !w));
    chk("wr_pulses", 64'(nwr), 64'(!ee && w));
    if (!ee && !w) chk("rd_data", (sel == 0) ? {32'd0, a_rd_data} : b_rd_data, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nacc, last, cnt;
    rst = 1'b1;
    a_valid = 1'b1; a_write = 1'b1; a_addr = 9'h010; a_wdata = 32'h5555_5555;
    a_size = 2'b10; a_signed = 1'b0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_size = '0; b_signed = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_reset_outs", 64'({a_ready, a_resp_valid, a_resp_err, a_stall, a_wr, a_rd,
        |a_dbg_addr, |a_resp_rdata, |a_wr_data, |a_rd_data}), 64'b10_0000_0000);
    chk("b_reset_outs", 64'({b_ready, b_resp_valid, b_resp_err, b_stall, b_wr, b_rd,
        |b_dbg_addr, |b_resp_rdata, |b_wr_data, |b_rd_data}), 64'b10_0000_0000);
    a_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("a_no_accept_in_reset", 64'(a_stall), 64'd0);

    // 32-bit instance, latency 1.
    issue(0, 1, 9'h010, 64'hDEAD_BEEF, 2'b10, 0, 0, 64'h0);
    issue(0, 0, 9'h010, 64'h0, 2'b10, 1, 0, 64'hDEAD_BEEF);
    issue(0, 1, 9'h013, 64'h80, 2'b00, 0, 0, 64'h0);
    issue(0, 0, 9'h013, 64'h0, 2'b00, 1, 0, 64'hFFFF_FF80);
    issue(0, 0, 9'h013, 64'h0, 2'b00, 0, 0, 64'h0000_0080);
    issue(0, 0, 9'h010, 64'h0, 2'b10, 0, 0, 64'h80AD_BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 0, 9'h011, 64'h0, 2'b01, 0, 1, 64'h0);
`else
    issue(0, 0, 9'h011, 64'h0, 2'b01, 0, 0, 64'h0000_BEEF);
`endif
    issue(0, 0, 9'h012, 64'h0, 2'b01, 1, 0, 64'hFFFF_80AD);
    issue(0, 0, 9'h010, 64'h0, 2'b11, 0, 1, 64'h0);
    issue(0, 1, 9'h016, 64'h1234, 2'b01, 0, 0, 64'h0);
    issue(0, 0, 9'h016, 64'h0, 2'b01, 0, 0, 64'h0000_1234);
    issue(0, 0, 9'h017, 64'h0, 2'b00, 1, 0, 64'h0000_0012);

    // 64-bit instance, latency 4.
    issue(1, 1, 9'h008, 64'h0123_4567_89AB_CDEF, 2'b11, 0, 0, 64'h0);
    issue(1, 0, 9'h00C, 64'h0, 2'b10, 1, 0, 64'h0000_0000_0123_4567);
    issue(1, 0, 9'h008, 64'h0, 2'b11, 0, 0, 64'h0123_4567_89AB_CDEF);
    issue(1, 0, 9'h008, 64'h0, 2'b10, 1, 0, 64'hFFFF_FFFF_89AB_CDEF);
    issue(1, 0, 9'h00A, 64'h0, 2'b01, 1, 0, 64'hFFFF_FFFF_FFFF_89AB);
    issue(1, 0, 9'h00F, 64'h0, 2'b00, 0, 0, 64'h0000_0000_0000_0001);

    // Continuous req_valid: one acceptance every MEM_LATENCY+2 cycles.
    b_valid = 1'b1; b_write = 1'b0; b_addr = 9'h008; b_size = 2'b11; b_signed = 1'b0;
    nacc = 0;
    last = 0;
    for (int c = 0; c < 18; c++) begin
      if (b_ready) begin
        q_b.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
        if (nacc > 0) chk("ready_gap", 64'(c - last), 64'd6);
        last = c;
        nacc++;
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
    chk("accept_count", 64'(nacc), 64'd3);

    // Reset during ACCESS of a store aborts it.
    issue(1, 1, 9'h020, 64'hCAFE_F00D, 2'b10, 0, 0, 64'h0);
    issue(1, 0, 9'h020, 64'h0, 2'b10, 0, 0, 64'h0000_0000_CAFE_F00D);
    b_valid = 1'b1; b_write = 1'b1; b_addr = 9'h020; b_wdata = 64'h1111_1111; b_size = 2'b10;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_access", 64'(b_stall), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_ready_async", 64'({b_ready, b_stall}), 64'b10);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cnt += int'(b_wr) + int'(b_resp_valid);
    end
    chk("abort_no_wr_resp", 64'(cnt), 64'd0);
    issue(1, 0, 9'h020, 64'h0, 2'b10, 0, 0, 64'h0000_0000_CAFE_F00D);

    for (int c = 0; c < 20 && (q_a.size() != 0 || q_b.size() != 0); c++) @(negedge clk);
    chk("a_queue_drained", 64'(q_a.size()), 64'd0);
    chk("b_queue_drained", 64'(q_b.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
